// File: rtl/neokeon_round_ctrl.sv
// Round sequencer for the Neokeon 128-bit state register: load strobe, NUM_ROUNDS
// round writes with the LFSR round constant, one final-transform write, then hold result.
module neokeon_round_ctrl #(
  parameter int          NUM_ROUNDS = 16,
  parameter logic [7:0]  RC_INIT    = 8'h80,
  parameter logic [7:0]  RC_LAST    = 8'hD4
) (
  input  logic       inClk,
  input  logic       inRst,
  input  logic       inStart,
  input  logic       inDecrypt,
  input  logic       inAck,
  output logic       outBusy,
  output logic       outValid,
  output logic       outExtWr,
  output logic       outIntWr,
  output logic       outFinal,
  output logic       outDecrypt,
  output logic [7:0] outRoundConst,
  output logic [4:0] outRoundIdx
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam logic [4:0] LAST_IDX  = 5'(NUM_ROUNDS - 1);
  localparam logic [4:0] FINAL_IDX = 5'(NUM_ROUNDS);

  state_t     state, state_next;
  logic [7:0] rc, rc_next;
  logic [4:0] cnt, cnt_next;
  logic       mode, mode_next;

  // Forward step is multiply-by-x in GF(2^8) mod x^8+x^4+x^3+x+1; backward step inverts it.
  function automatic logic [7:0] rc_fwd(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] rc_bwd(input logic [7:0] r);
    return r[0] ? (({1'b0, r[7:1]} ^ 8'h0D) | 8'h80) : {1'b0, r[7:1]};
  endfunction

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      state <= IDLE;
      rc    <= RC_INIT;
      cnt   <= '0;
      mode  <= 1'b0;
    end else begin
      state <= state_next;
      rc    <= rc_next;
      cnt   <= cnt_next;
      mode  <= mode_next;
    end
  end

  always_comb begin
    state_next = state;
    rc_next    = rc;
    cnt_next   = cnt;
    mode_next  = mode;
    case (state)
      IDLE: begin
        if (inStart) begin
          mode_next  = inDecrypt;
          rc_next    = inDecrypt ? RC_LAST : RC_INIT;
          cnt_next   = '0;
          state_next = LOAD;
        end
      end
      LOAD: state_next = ROUND;
      ROUND: begin
        cnt_next = cnt + 5'd1;
        rc_next  = mode ? rc_bwd(rc) : rc_fwd(rc);
        if (cnt == LAST_IDX) state_next = FINAL;
      end
      FINAL: state_next = DONE;
      DONE: begin
        if (inAck) begin
          if (inStart) begin
            mode_next  = inDecrypt;
            rc_next    = inDecrypt ? RC_LAST : RC_INIT;
            cnt_next   = '0;
            state_next = LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs depend only on registered state so the datapath never sees input glitches.
  always_comb begin
    outBusy       = 1'b0;
    outValid      = 1'b0;
    outExtWr      = 1'b0;
    outIntWr      = 1'b0;
    outFinal      = 1'b0;
    outDecrypt    = 1'b0;
    outRoundConst = 8'h00;
    outRoundIdx   = 5'd0;
    case (state)
      LOAD: begin
        outBusy    = 1'b1;
        outExtWr   = 1'b1;
        outDecrypt = mode;
      end
      ROUND: begin
        outBusy       = 1'b1;
        outIntWr      = 1'b1;
        outDecrypt    = mode;
        outRoundConst = rc;
        outRoundIdx   = cnt;
      end
      FINAL: begin
        outBusy       = 1'b1;
        outIntWr      = 1'b1;
        outFinal      = 1'b1;
        outDecrypt    = mode;
        outRoundConst = rc;
        outRoundIdx   = FINAL_IDX;
      end
      DONE: begin
        outValid   = 1'b1;
        outDecrypt = mode;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/neokeon_round_ctrl.md
Name: neokeon_round_ctrl

Overview:
- Sequencer for the 128-bit Neokeon round-state register and round-function datapath.
- Accepts a start request and issues the load strobe (plaintext/ciphertext into the round register).
- Then issues NUM_ROUNDS round-write strobes with the matching 8-bit round constant, followed by one final-transform write.
- Holds a result-valid flag until the consumer acknowledges it. Supports encrypt and decrypt; decrypt runs the constant sequence in reverse.

Parameters:
- NUM_ROUNDS, 16: number of full rounds before the final output transform (1..30).
- RC_INIT, 8'h80: first encryption round constant.
- RC_LAST, 8'hD4: constant for the final transform. It is the first decryption constant and must equal RC_INIT advanced NUM_ROUNDS times by the LFSR.

Ports:
- inClk  input  1  clock; all state changes on rising edge
- inRst  input  1  asynchronous reset, active-high
- inStart  input  1  start request; sampled only in IDLE, or in DONE together with inAck
- inDecrypt  input  1  mode: 0 = encrypt, 1 = decrypt; latched when start is accepted
- inAck  input  1  consumer acknowledge of result
- outBusy  output  1  high in LOAD, ROUND, FINAL
- outValid  output  1  high in DONE; round register holds the result
- outExtWr  output  1  round-register external write (load input block)
- outIntWr  output  1  round-register internal write (round datapath result)
- outFinal  output  1  selects the final-transform path of the round datapath
- outDecrypt  output  1  latched mode, drives the key-theta select in the datapath
- outRoundConst  output  8  current round constant; 8'h00 outside ROUND/FINAL
- outRoundIdx  output  5  current round index 0..NUM_ROUNDS; 0 outside ROUND/FINAL

Behaviour:
- Reset (async, any state): state = IDLE, rc = RC_INIT, round counter = 0, mode = 0. All outputs are 0. Reset mid-operation abandons the operation with no further write strobes.
- Moore FSM. All outputs are decoded from registered state, counter, rc and mode only; no input-to-output combinational paths.
- IDLE:
  - Outputs 0.
  - If inStart = 1: latch mode = inDecrypt; set rc = RC_INIT if encrypting, RC_LAST if decrypting; counter = 0; go to LOAD.
  - inDecrypt is ignored in IDLE without start.
- LOAD (1 cycle): outExtWr = 1, outBusy = 1. Next state ROUND.
- ROUND (NUM_ROUNDS cycles):
  - outIntWr = 1, outBusy = 1, outRoundConst = rc, outRoundIdx = counter.
  - Each cycle: counter increments and rc steps. Encrypt: rc_next = {rc[6:0],1'b0} ^ (rc[7] ? 8'h1B : 8'h00). Decrypt: rc_next = rc[0] ? ({1'b0,rc[7:1]} ^ 8'h0D) | 8'h80 : {1'b0,rc[7:1]}.
  - After the write with counter = NUM_ROUNDS-1, go to FINAL.
- FINAL (1 cycle): outIntWr = 1, outFinal = 1, outBusy = 1, outRoundConst = rc, outRoundIdx = NUM_ROUNDS. Next state DONE.
- DONE:
  - outValid = 1; write strobes 0.
  - inAck = 0: hold in DONE.
  - inAck = 1 and inStart = 0: go to IDLE.
  - inAck = 1 and inStart = 1: back-to-back start. Latch new mode and rc, go to LOAD directly.
- Latency: start accepted at edge E0 → input captured by register at E1 → rounds written at E2..E(NUM_ROUNDS+1) → final at E(NUM_ROUNDS+2). outValid rises after E(NUM_ROUNDS+2), i.e. 18 edges for the default.
- inStart while busy is ignored, with no queuing. inAck outside DONE is ignored.
- outExtWr and outIntWr are never high in the same cycle.
- Exactly one outExtWr pulse and NUM_ROUNDS+1 outIntWr pulses per operation.
- Mode and rc are frozen from acceptance to DONE; input changes mid-run have no effect.

Test Plan:
- Reset then encrypt start (inDecrypt = 0):
  - outExtWr for 1 cycle, then 17 outIntWr cycles.
  - outRoundConst = 80,1B,36,6C,D8,AB,4D,9A,2F,5E,BC,63,C6,97,35,6A, then D4 with outFinal = 1.
  - outRoundIdx = 0..16; outValid after 18 edges.
- Decrypt start: outRoundConst sequence is D4,6A,35,97,C6,63,BC,5E,2F,9A,4D,AB,D8,6C,36,1B, then 80 with outFinal = 1.
- Hold inAck = 0 for 10 cycles in DONE → outValid stays 1 and no write strobes. inAck = 1 → IDLE next cycle, all outputs 0.
- Pulse inStart and toggle inDecrypt during ROUND → no effect on sequence, count or outValid timing.
- In DONE, assert inAck = 1 and inStart = 1 with inDecrypt = 1 → next cycle LOAD (outExtWr = 1, outValid = 0), followed by the decrypt constant sequence.
- Assert inRst asynchronously during ROUND at round 7 → outputs 0 immediately. After release, a new encrypt start replays the full sequence from 80.
